usart_tx_ctrl: RTL and testbench



---
 rtl/usart_tx_ctrl.sv | 143 ++++++++++++++
 tb/tb_usart_tx_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// usart_tx_ctrl
//
// Transmit controller for the USART Tx path. Arbitrates between two byte
// requesters with a request/acknowledge handshake and serialises the granted
// byte as an 8N1 frame (start 0, D0..D7 LSB first, stop 1). Baud timing and
// start/data/stop sequencing are owned here. All outputs are registered.
//
// Ports:
//   CLK        in   system clock, rising edge
//   CLR_N      in   asynchronous active-low reset
//   REQ0/REQ1  in   byte request levels from requesters 0/1
//   DATA0/1    in   request bytes, stable while the matching REQ is high
//   ACK0/ACK1  out  one-cycle pulse: matching DATA captured
//   SERIAL_OUT out  serial line, idle high
//   BUSY       out  high whenever a frame is in flight (state != IDLE)
//   GRANT      out  index of the requester most recently captured
// ----------------------------------------------------------------------------
module usart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       REQ0,
    input  logic [7:0] DATA0,
    output logic       ACK0,
    input  logic       REQ1,
    input  logic [7:0] DATA1,
    output logic       ACK1,
    output logic       SERIAL_OUT,
    output logic       BUSY,
    output logic       GRANT
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           r_state;
    logic [BaudW-1:0] r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_rr;      // requester favoured on the next conflict
    logic             r_grant;
    logic             r_ser;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_busy;

    logic             w_req_any;
    logic             w_sel;
    logic             w_baud_last;

    assign w_req_any   = REQ0 | REQ1;
    // Conflict goes to the round-robin pointer; otherwise the lone requester wins.
    assign w_sel       = (REQ0 & REQ1) ? r_rr : REQ1;
    assign w_baud_last = (r_baud == BaudLast);

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rr      <= 1'b0;
            r_grant   <= 1'b0;
            r_ser     <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    if (w_req_any) begin
                        r_shift <= w_sel ? DATA1 : DATA0;
                        r_ack0  <= ~w_sel;
                        r_ack1  <= w_sel;
                        r_grant <= w_sel;
                        r_rr    <= ~w_sel;
                        r_ser   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_ser     <= r_shift[0];
                        r_state   <= StData;
                    end else begin
                        r_baud <= r_baud + BaudW'(1);
                    end
                end
                StData: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_ser   <= 1'b1;
                            r_state <= StStop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_ser     <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + BaudW'(1);
                    end
                end
                StStop: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_baud <= r_baud + BaudW'(1);
                    end
                end
                default: begin
                    r_ser   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ACK0       = r_ack0;
    assign ACK1       = r_ack1;
    assign SERIAL_OUT = r_ser;
    assign BUSY       = r_busy;
    assign GRANT      = r_grant;

endmodule

// File: tb/tb_usart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_usart_tx_ctrl
//
// Requesters hold per-requester byte queues. A frame-level reference model
// decides, on each rising edge, whether a capture happens (line free and a
// request up) and which requester wins, and pushes the expected byte/grant
// into a scoreboard queue. A separate monitor pops that queue when the frame
// should begin and checks the ACK pulse, GRANT and the full 10-bit waveform.
// ----------------------------------------------------------------------------
module tb_usart_tx_ctrl;

    localparam int unsigned C        = 4;
    localparam int          FrameLen = 10 * C;

    logic       clk   = 1'b0;
    logic       clr_n = 1'b1;
    logic       req0  = 1'b0;
    logic       req1  = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, ser, busy, grant;

    always #5 clk = ~clk;

    usart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
        .CLK       (clk),
        .CLR_N     (clr_n),
        .REQ0      (req0),
        .DATA0     (data0),
        .ACK0      (ack0),
        .REQ1      (req1),
        .DATA1     (data1),
        .ACK1      (ack1),
        .SERIAL_OUT(ser),
        .BUSY      (busy),
        .GRANT     (grant)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         g;
        logic [7:0] d;
    } rec_t;

    rec_t       exp_q[$];
    logic [7:0] pend0[$];
    logic [7:0] pend1[$];
    int         gapmax   = 0;
    int         cyc      = 0;
    int         m_free   = 0;
    bit         m_rr     = 1'b0;
    int         m_last_k = -1;
    bit         mon_act  = 1'b0;

    // One clock: model decision at the rising edge, requester drive at the falling edge.
    task automatic step();
        bit   g;
        bit   drop0;
        bit   drop1;
        rec_t r;
        drop0 = 1'b0;
        drop1 = 1'b0;
        @(posedge clk);
        cyc++;
        if (!clr_n) begin
            m_free = cyc + 1;
            m_rr   = 1'b0;
        end else if (cyc >= m_free && (req0 || req1)) begin
            g   = (req0 && req1) ? m_rr : req1;
            r.g = g;
            r.d = g ? pend1.pop_front() : pend0.pop_front();
            exp_q.push_back(r);
            m_rr     = !g;
            m_free   = cyc + FrameLen + 1;
            m_last_k = cyc;
            if (g) drop1 = 1'b1;
            else   drop0 = 1'b1;
        end
        @(negedge clk);
        if (drop0) req0 = 1'b0;
        if (drop1) req1 = 1'b0;
        if (!req0) begin
            if (pend0.size() > 0 && $urandom_range(gapmax) == 0) begin
                req0  = 1'b1;
                data0 = pend0[0];
            end else begin
                data0 = 8'($urandom);
            end
        end
        if (!req1) begin
            if (pend1.size() > 0 && $urandom_range(gapmax) == 0) begin
                req1  = 1'b1;
                data1 = pend1[0];
            end else begin
                data1 = 8'($urandom);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called just after a falling edge; asserts reset asynchronously and checks it took.
    task automatic do_reset(input string tag);
        #2 clr_n = 1'b0;
        #1;
        chk({tag, "_ser"}, ser, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_acks"}, {ack1, ack0}, 2'b00);
        chk({tag, "_grant"}, grant, 1'b0);
        step();
        step();
        #2 clr_n = 1'b1;
    endtask

    // Scoreboard monitor.
    initial begin
        rec_t       cur;
        int         s;
        logic [9:0] fr;
        logic [9:0] bad_bits;
        logic [9:0] mid;
        int         extra_ack;
        int         busy_low;
        int         grant_bad;
        s = 0;
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                mon_act = 1'b0;
                exp_q.delete();
            end else begin
                if (!mon_act) begin
                    if (exp_q.size() > 0) begin
                        cur       = exp_q.pop_front();
                        mon_act   = 1'b1;
                        s         = 0;
                        fr        = {1'b1, cur.d, 1'b0};
                        bad_bits  = '0;
                        mid       = '0;
                        extra_ack = 0;
                        busy_low  = 0;
                        grant_bad = 0;
                        chk("ack_pulse", {ack1, ack0}, cur.g ? 2'b10 : 2'b01);
                        chk("grant", grant, cur.g);
                    end else begin
                        chk("idle_line", {ack1, ack0, busy, ser}, 4'b0001);
                    end
                end
                if (mon_act) begin
                    if (s < FrameLen) begin
                        if (ser !== fr[s / C]) bad_bits[s / C] = 1'b1;
                        if (s % C == C / 2) mid[s / C] = ser;
                        if (s > 0 && (ack0 || ack1)) extra_ack++;
                        if (busy !== 1'b1) busy_low++;
                        if (grant !== cur.g) grant_bad++;
                        s++;
                    end else begin
                        chk("bit_timing", bad_bits, 10'h000);
                        chk("data_byte", mid[8:1], cur.d);
                        chk("start_stop", {mid[9], mid[0]}, 2'b10);
                        chk("ack_single", extra_ack, 0);
                        chk("busy_frame", busy_low, 0);
                        chk("grant_hold", grant_bad, 0);
                        chk("return_idle", {busy, ser}, 2'b01);
                        mon_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int bound;
        #1 clr_n = 1'b0;
        #1;
        chk("rst_ser", ser, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acks", {ack1, ack0}, 2'b00);
        chk("rst_grant", grant, 1'b0);
        step();
        step();
        #2 clr_n = 1'b1;

        // Contention straight after reset: 0x55 (req 0) first, then 0xA3.
        pend0.push_back(8'h55);
        pend1.push_back(8'hA3);
        steps(2 * (FrameLen + 1) + 6);

        // Single byte.
        pend0.push_back(8'h0B);
        steps(FrameLen + 6);

        // Round-robin with both requesters held busy.
        pend0.push_back(8'h11);
        pend0.push_back(8'h22);
        pend1.push_back(8'h33);
        pend1.push_back(8'h44);
        steps(4 * (FrameLen + 1) + 6);

        // Late request from requester 1 during a 0x00 frame.
        pend0.push_back(8'h00);
        steps(10);
        pend1.push_back(8'h81);
        steps(2 * (FrameLen + 1) + 6);

        // Reset during data bit 3 of a requester-1 frame, requester 0 waiting.
        pend1.push_back(8'hF0);
        bound = m_last_k;
        for (int i = 0; i < 10 && m_last_k == bound; i++) step();
        chk("rst_frame_started", (m_last_k != bound), 1'b1);
        pend0.push_back(8'h3C);
        steps(4 * C + 1);
        chk("pre_reset_busy", busy, 1'b1);
        do_reset("midrst");
        steps(FrameLen + 6);

        // Randomised traffic with random request gaps.
        gapmax = 6;
        for (int i = 0; i < 6; i++) begin
            pend0.push_back(8'($urandom));
            pend1.push_back(8'($urandom));
        end
        bound = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || exp_q.size() > 0 || mon_act)
               && bound < 1500) begin
            step();
            bound++;
        end
        chk("random_drain", (bound < 1500), 1'b1);
        steps(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
